report_collector: RTL and testbench

- Consumer end of the STE array: samples the active_state outputs of all reporting STEs on every symbol cycle.
- Tags each cycle with any active report with its symbol offset and buffers it as a report record in a FIFO.
- Drains records to the host/CSR side over a valid/ready handshake.
- Sits next to the cluster, on the same run/start_of_data stream that drives the STEs.

---
 rtl/report_collector.sv | 107 ++++++++++
 tb/tb_report_collector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/report_collector.sv
// Collects STE report vectors into a record FIFO, tagging each hit with its
// symbol offset, and drains the records over a valid/ready handshake.
module report_collector #(
  parameter int NUM_REPORTS  = 8,
  parameter int OFFSET_WIDTH = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int DROP_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic                          start_of_data,
  input  logic [NUM_REPORTS-1:0]        report_states,
  output logic                          rpt_valid,
  input  logic                          rpt_ready,
  output logic [OFFSET_WIDTH-1:0]       rpt_offset,
  output logic [NUM_REPORTS-1:0]        rpt_vector,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [DROP_WIDTH-1:0]         drop_count,
  input  logic                          clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] offset;
    logic [NUM_REPORTS-1:0]  vector;
  } rec_t;

  rec_t                    mem [FIFO_DEPTH];
  rec_t                    head;
  rec_t                    rec_in;
  logic [AW-1:0]           rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]           count;
  logic [OFFSET_WIDTH-1:0] offset_cnt, idx;
  logic                    hit, push, pop, drop;

  assign idx    = start_of_data ? '0 : offset_cnt;
  assign hit    = run & (|report_states);
  assign rec_in = '{offset: idx, vector: report_states};

  // valid is decoded from the registered count only, never from rpt_ready
  assign rpt_valid = (count != '0);
  assign pop       = rpt_valid & rpt_ready;
  assign push      = hit & ((count != FULL) | pop);
  assign drop      = hit & ~push;
  assign rd_nxt    = rd_ptr + AW'(1);

  assign rpt_offset = head.offset;
  assign rpt_vector = head.vector;
  assign fifo_count = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  offset_cnt <= '0;
    else if (run)  offset_cnt <= idx + OFFSET_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head register: next stored entry on pop, or the incoming record when the
  // FIFO is (or is becoming) empty; otherwise it keeps the last value shown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      head <= '0;
    else if (pop && count > CW'(1))
      head <= mem[rd_nxt];
    else if (push && (count == '0 || (pop && count == CW'(1))))
      head <= rec_in;
  end

  // A drop in the clearing cycle wins: it restarts the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clear_overflow)   drop_count <= DROP_WIDTH'(1);
      else if (~&drop_count) drop_count <= drop_count + DROP_WIDTH'(1);
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_report_collector.sv
// Directed bench for report_collector: default instance plus a narrow-offset,
// deep-FIFO instance for counter wrap and mid-drain reset.
module tb_report_collector;
  logic        clk = 1'b0;
  logic        reset_n, run, sod, ready, clr;
  logic [7:0]  rs;
  logic        valid, ovf;
  logic [31:0] off;
  logic [7:0]  vec;
  logic [4:0]  cnt;
  logic [15:0] drops;

  logic        rst2_n, run2, sod2, ready2, valid2, ovf2;
  logic [7:0]  rs2, vec2;
  logic [3:0]  off2;
  logic [5:0]  cnt2;
  logic [15:0] drops2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  report_collector dut (
    .clk(clk), .reset_n(reset_n), .run(run), .start_of_data(sod),
    .report_states(rs), .rpt_valid(valid), .rpt_ready(ready),
    .rpt_offset(off), .rpt_vector(vec), .fifo_count(cnt),
    .overflow(ovf), .drop_count(drops), .clear_overflow(clr));

  report_collector #(.OFFSET_WIDTH(4), .FIFO_DEPTH(32)) dut2 (
    .clk(clk), .reset_n(rst2_n), .run(run2), .start_of_data(sod2),
    .report_states(rs2), .rpt_valid(valid2), .rpt_ready(ready2),
    .rpt_offset(off2), .rpt_vector(vec2), .fifo_count(cnt2),
    .overflow(ovf2), .drop_count(drops2), .clear_overflow(1'b0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic r, input logic s, input logic [7:0] v, input logic rd);
    run = r; sod = s; rs = v; ready = rd;
    tk();
  endtask

  initial begin
    reset_n = 1'b0; run = 0; sod = 0; rs = 0; ready = 0; clr = 0;
    rst2_n = 1'b0; run2 = 0; sod2 = 0; rs2 = 0; ready2 = 0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_offset", off, 0);
    chk("rst_vector", vec, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drops", drops, 0);
    tk(); tk();
    reset_n = 1'b1;

    // single hit on symbol 3
    for (int s = 0; s < 10; s++) begin
      step(1'b1, s == 0, (s == 3) ? 8'h04 : 8'h00, 1'b0);
      if (s == 2) chk("t1_valid_before", valid, 0);
      if (s == 3) begin
        chk("t1_valid_rise", valid, 1);
        chk("t1_offset", off, 3);
        chk("t1_vector", vec, 8'h04);
      end
    end
    chk("t1_count", cnt, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t1_empty_valid", valid, 0);
    chk("t1_empty_count", cnt, 0);
    chk("t1_hold_offset", off, 3);
    chk("t1_hold_vector", vec, 8'h04);

    // bubbles, restart at symbol 5, sod ignored while run=0
    step(1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int s = 1; s < 5; s++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h10, 1'b0);
    chk("t2_no_bubble_rec", cnt, 0);
    step(1'b1, 1'b0, 8'h21, 1'b0);
    chk("t2_count1", cnt, 1);
    chk("t2_offset", off, 1);
    chk("t2_vector", vec, 8'h21);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    chk("t2_count2", cnt, 2);
    chk("t2_head_kept", off, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_pop_offset", off, 2);
    chk("t2_pop_vector", vec, 8'h02);
    chk("t2_pop_count", cnt, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_drained", valid, 0);

    // overflow: 20 hits into 16 entries, then stalled drain
    for (int s = 0; s < 20; s++) step(1'b1, s == 0, 8'(s + 1), 1'b0);
    chk("t3_count_full", cnt, 16);
    chk("t3_ovf", ovf, 1);
    chk("t3_drops", drops, 4);
    for (int k = 0; k < 16; k++) begin
      chk("t3_drain_offset", off, k);
      chk("t3_drain_vector", vec, k + 1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("t3_stall_offset", off, k);
      chk("t3_stall_vector", vec, k + 1);
      chk("t3_stall_valid", valid, 1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("t3_drained", cnt, 0);

    // full FIFO, push and pop together
    for (int s = 0; s < 16; s++) step(1'b1, s == 0, 8'(s + 1), 1'b0);
    chk("t4_full", cnt, 16);
    step(1'b1, 1'b0, 8'hAA, 1'b1);
    chk("t4_count_same", cnt, 16);
    chk("t4_no_drop", drops, 4);
    chk("t4_head", off, 1);
    for (int k = 0; k < 16; k++) begin
      chk("t4_order_offset", off, k + 1);
      chk("t4_order_vector", vec, (k == 15) ? 8'hAA : 8'(k + 2));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("t4_drained", cnt, 0);

    // clear_overflow alone, then in a drop cycle
    clr = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    clr = 1'b0;
    chk("t5_clr_ovf", ovf, 0);
    chk("t5_clr_drops", drops, 0);
    for (int s = 0; s < 16; s++) step(1'b1, s == 0, 8'h01, 1'b0);
    clr = 1'b1;
    step(1'b1, 1'b0, 8'h55, 1'b0);
    clr = 1'b0;
    chk("t5_drop_wins_ovf", ovf, 1);
    chk("t5_drop_wins_cnt", drops, 1);
    chk("t5_still_full", cnt, 16);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_drained", cnt, 0);

    // 4-bit offset wrap, then reset mid-drain
    rst2_n = 1'b1;
    tk();
    for (int s = 0; s < 18; s++) begin
      run2 = 1'b1; sod2 = (s == 0); rs2 = 8'(s + 1); ready2 = 1'b0;
      tk();
    end
    run2 = 1'b0; sod2 = 1'b0; rs2 = 8'h00;
    chk("t6_count", cnt2, 18);
    chk("t6_no_ovf", ovf2, 0);
    ready2 = 1'b1;
    for (int k = 0; k < 17; k++) begin
      chk("t6_wrap_offset", off2, k % 16);
      chk("t6_wrap_vector", vec2, k + 1);
      tk();
    end
    ready2 = 1'b0;
    chk("t6_last_count", cnt2, 1);
    chk("t6_last_offset", off2, 1);
    chk("t6_last_vector", vec2, 18);
    #2 rst2_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid2, 0);
    chk("t6_rst_count", cnt2, 0);
    chk("t6_rst_offset", off2, 0);
    tk();
    rst2_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
